// File: rtl/time_digit_loader_if.sv
// Host-side bus of the time digit loader.
//   din, din_valid : serial time word, MSB first, one bit per valid edge
//   tick           : single-cycle request to advance the committed time
//   time_out       : committed time (packed BCD digits, digit 0 in the LSBs)
//   update_toggle  : inverts whenever time_out changes (CDC handshake)
//   frame_done/err/drop : one-cycle event pulses
//   err_count      : saturating count of rejected plus dropped frames
// Modports: master drives the serial input side, slave is the loader.
interface time_digit_loader_if #(
  parameter int unsigned FRAME_W = 24
);
  logic               din;
  logic               din_valid;
  logic               tick;
  logic [FRAME_W-1:0] time_out;
  logic               update_toggle;
  logic               frame_done;
  logic               frame_err;
  logic               frame_drop;
  logic [7:0]         err_count;

  modport master (
    output din, din_valid, tick,
    input  time_out, update_toggle, frame_done, frame_err, frame_drop, err_count
  );

  modport slave (
    input  din, din_valid, tick,
    output time_out, update_toggle, frame_done, frame_err, frame_drop, err_count
  );
endinterface

// File: rtl/time_digit_loader.sv
// Serial loader for the wall-clock time digits (wclk domain).
// Shifts in NUM_DIGITS BCD digits MSB first, range-checks each digit and commits only
// complete legal frames to time_out. A partial frame left idle for TIMEOUT cycles is
// discarded. Optional feature macro TIME_DIGIT_LOADER_TICK_EN: bus.tick advances the
// committed time by one count with per-digit rollover (and 23 -> 00 hour wrap).
// Ports:
//   wclk  : clock
//   reset : synchronous, active-high
//   bus   : time_digit_loader_if slave (din/din_valid/tick in; time and events out)
// All outputs are registered.
module time_digit_loader #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned DIGIT_W = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MAX = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9},
  parameter int unsigned TIMEOUT = 1000,
  parameter bit HOUR_WRAP_EN_P = 1'b1
) (
  input logic                wclk,
  input logic                reset,
  time_digit_loader_if.slave bus
);

  localparam int unsigned FRAME_BITS = NUM_DIGITS * DIGIT_W;
  localparam int unsigned CntW = $clog2(FRAME_BITS + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);
  localparam logic [IdleW-1:0] IdleOne = IdleW'(1);
  localparam bit PairWrap = HOUR_WRAP_EN_P && (NUM_DIGITS >= 2);
  localparam int unsigned TopLo = (NUM_DIGITS - 1) * DIGIT_W;
  localparam int unsigned NextLo = (NUM_DIGITS >= 2) ? (NUM_DIGITS - 2) * DIGIT_W : 0;

  typedef enum logic [0:0] {StIdle, StRecv} state_e;

  state_e                  state_q, state_d;
  // Only FRAME_BITS-1 bits are stored: the last bit is taken straight from din.
  logic [FRAME_BITS-2:0]   shift_q, shift_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [IdleW-1:0]        idle_cnt_q, idle_cnt_d;
  logic [FRAME_BITS-1:0]   time_q, time_d;
  logic                    toggle_q, toggle_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    drop_q, drop_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [FRAME_BITS-1:0]   full_word;
  logic                    word_ok;
  logic                    commit;

  // Value of the top digit pair read as a two-digit decimal number (hours).
  function automatic logic [31:0] pair_value(input logic [FRAME_BITS-1:0] w);
    return 32'(w[TopLo +: DIGIT_W]) * 32'd10 + 32'(w[NextLo +: DIGIT_W]);
  endfunction

  assign full_word = {shift_q, bus.din};

  always_comb begin
    word_ok = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (full_word[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX[i*DIGIT_W +: DIGIT_W]) begin
        word_ok = 1'b0;
      end
    end
    if (PairWrap && (pair_value(full_word) > 32'd23)) begin
      word_ok = 1'b0;
    end
  end

`ifdef TIME_DIGIT_LOADER_TICK_EN
  logic [FRAME_BITS-1:0] tick_word;
  logic                  carry;
  localparam logic [DIGIT_W-1:0] DigitOne = DIGIT_W'(1);

  // Ripple increment: a digit at its maximum rolls to 0 and carries upward;
  // the top digit simply wraps.
  always_comb begin
    tick_word = time_q;
    carry     = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (carry) begin
        if (tick_word[i*DIGIT_W +: DIGIT_W] >= DIGIT_MAX[i*DIGIT_W +: DIGIT_W]) begin
          tick_word[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          tick_word[i*DIGIT_W +: DIGIT_W] = tick_word[i*DIGIT_W +: DIGIT_W] + DigitOne;
          carry = 1'b0;
        end
      end
    end
    if (PairWrap && (pair_value(tick_word) == 32'd24)) begin
      tick_word[TopLo +: DIGIT_W]  = '0;
      tick_word[NextLo +: DIGIT_W] = '0;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = bus.tick;
`endif

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    time_d      = time_q;
    toggle_d    = toggle_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    drop_d      = 1'b0;
    err_count_d = err_count_q;
    commit      = 1'b0;

    if (bus.din_valid) begin
      shift_d    = full_word[FRAME_BITS-2:0];
      idle_cnt_d = '0;
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d = '0;
        state_d   = StIdle;
        if (word_ok) begin
          time_d   = full_word;
          toggle_d = ~toggle_q;
          done_d   = 1'b1;
          commit   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + CntOne;
        state_d   = StRecv;
      end
    end else if (state_q == StRecv) begin
      if (idle_cnt_q == IdleLast) begin
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
        state_d    = StIdle;
        drop_d     = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IdleOne;
      end
    end

`ifdef TIME_DIGIT_LOADER_TICK_EN
    // A commit on the same edge wins; a rejected frame leaves time_q to the tick.
    if (bus.tick && !commit) begin
      time_d = tick_word;
      if (tick_word != time_q) begin
        toggle_d = ~toggle_q;
      end
    end
`endif

    // err_d and drop_d are mutually exclusive, so one increment covers both.
    if ((err_d || drop_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      time_q      <= '0;
      toggle_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      time_q      <= time_d;
      toggle_q    <= toggle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.time_out      = time_q;
  assign bus.update_toggle = toggle_q;
  assign bus.frame_done    = done_q;
  assign bus.frame_err     = err_q;
  assign bus.frame_drop    = drop_q;
  assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_time_digit_loader.sv
// Bench for time_digit_loader: directed checks against literal values plus randomized
// frames, gaps, ticks and resets checked every cycle against a time-of-day model.
module tb_time_digit_loader;
  localparam int TO = 16;

  logic wclk = 1'b0;
  logic reset;
  always #5 wclk = ~wclk;

  time_digit_loader_if #(.FRAME_W(24)) bus ();

  time_digit_loader #(
    .TIMEOUT(TO)
  ) dut (
    .wclk (wclk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model state.
  logic [23:0] m_time, m_acc;
  bit          m_tog, m_done, m_err, m_drop;
  int          m_errcnt, m_bits, m_idle;

  function automatic bit time_ok(input logic [23:0] w);
    int d[6];
    for (int i = 0; i < 6; i++) d[i] = int'(w[4*i +: 4]);
    return d[5] <= 2 && d[4] <= 9 && d[3] <= 5 && d[2] <= 9 && d[1] <= 5 && d[0] <= 9 &&
           (d[5] * 10 + d[4]) <= 23;
  endfunction

  function automatic logic [23:0] secs_to_bcd(input int s);
    int h = s / 3600;
    int m = (s / 60) % 60;
    int c = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int bcd_to_secs(input logic [23:0] w);
    return (int'(w[23:20]) * 10 + int'(w[19:16])) * 3600 +
           (int'(w[15:12]) * 10 + int'(w[11:8])) * 60 +
           (int'(w[7:4]) * 10 + int'(w[3:0]));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // What one clock edge must do, in time-of-day terms.
  task automatic model_edge(input bit d, input bit dv, input bit tk, input bit rst);
    bit commit = 1'b0;
    logic [23:0] nt;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_drop = 1'b0;
    if (rst) begin
      m_time = '0; m_tog = 1'b0; m_errcnt = 0; m_bits = 0; m_idle = 0; m_acc = '0;
      return;
    end
    if (dv) begin
      m_acc = {m_acc[22:0], d};
      m_bits++;
      m_idle = 0;
      if (m_bits == 24) begin
        m_bits = 0;
        if (time_ok(m_acc)) begin
          m_time = m_acc; m_tog = ~m_tog; m_done = 1'b1; commit = 1'b1;
        end else begin
          m_err = 1'b1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
    end else if (m_bits > 0) begin
      m_idle++;
      if (m_idle == TO) begin
        m_bits = 0; m_idle = 0; m_drop = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
`ifdef TIME_DIGIT_LOADER_TICK_EN
    if (tk && !commit) begin
      nt = secs_to_bcd((bcd_to_secs(m_time) + 1) % 86400);
      if (nt != m_time) m_tog = ~m_tog;
      m_time = nt;
    end
`else
    nt = '0;
    if (tk && commit && nt != '0) m_time = nt;
`endif
  endtask

  task automatic step(input bit d, input bit dv, input bit tk, input bit rst);
    @(negedge wclk);
    bus.din       = d;
    bus.din_valid = dv;
    bus.tick      = tk;
    reset         = rst;
    @(posedge wclk);
    model_edge(d, dv, tk, rst);
    chk_en = 1'b1;
  endtask

  task automatic send_frame(input logic [23:0] w, input bit tk_last);
    for (int i = 23; i >= 0; i--) step(w[i], 1'b1, (i == 0) ? tk_last : 1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge wclk) begin
    if (chk_en) begin
      chk("time_out", 32'(bus.time_out), 32'(m_time));
      chk("update_toggle", 32'(bus.update_toggle), 32'(m_tog));
      chk("frame_done", 32'(bus.frame_done), 32'(m_done));
      chk("frame_err", 32'(bus.frame_err), 32'(m_err));
      chk("frame_drop", 32'(bus.frame_drop), 32'(m_drop));
      chk("err_count", 32'(bus.err_count), 32'(m_errcnt));
    end
  end

  initial begin
    logic [23:0] w;
    bus.din = 1'b0; bus.din_valid = 1'b0; bus.tick = 1'b0; reset = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset time_out", 32'(bus.time_out), 32'h0);
    chk("reset toggle", 32'(bus.update_toggle), 32'h0);
    chk("reset err_count", 32'(bus.err_count), 32'h0);
    chk("reset pulses", {29'd0, bus.frame_done, bus.frame_err, bus.frame_drop}, 32'h0);

    send_frame(24'h123456, 1'b0);
    #1;
    chk("commit 123456", 32'(bus.time_out), 32'h123456);
    chk("commit done", 32'(bus.frame_done), 32'h1);
    chk("commit toggle", 32'(bus.update_toggle), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("done one cycle", 32'(bus.frame_done), 32'h0);

    send_frame(24'h2A0000, 1'b0);
    #1;
    chk("reject 2A0000", 32'(bus.frame_err), 32'h1);
    send_frame(24'h240000, 1'b0);
    #1;
    chk("reject 240000", 32'(bus.frame_err), 32'h1);
    chk("reject keeps time", 32'(bus.time_out), 32'h123456);
    chk("reject err_count", 32'(bus.err_count), 32'h2);

    w = 24'hFFFFFF;
    for (int i = 0; i < 10; i++) step(w[i], 1'b1, 1'b0, 1'b0);
    repeat (TO - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("no drop before timeout", 32'(bus.frame_drop), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("drop at timeout", 32'(bus.frame_drop), 32'h1);
    chk("drop err_count", 32'(bus.err_count), 32'h3);
    send_frame(24'h000102, 1'b0);
    #1;
    chk("commit after drop", 32'(bus.time_out), 32'h000102);

    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(24'h010203, 1'b0);
    #1;
    chk("commit after reset", 32'(bus.time_out), 32'h010203);
    chk("no err after reset", {30'd0, bus.frame_err, bus.frame_drop}, 32'h0);

`ifdef TIME_DIGIT_LOADER_TICK_EN
    send_frame(24'h235959, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("tick 235959", 32'(bus.time_out), 32'h000000);
    send_frame(24'h095959, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("tick 095959", 32'(bus.time_out), 32'h100000);
    send_frame(24'h111111, 1'b1);
    #1;
    chk("tick vs commit", 32'(bus.time_out), 32'h111111);
    send_frame(24'hFFFFFF, 1'b1);
    #1;
    chk("tick with reject", 32'(bus.time_out), 32'h111112);
`else
    send_frame(24'h235959, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("tick ignored", 32'(bus.time_out), 32'h235959);
`endif

    // Saturation of err_count.
    repeat (260) send_frame(24'hFFFFFF, 1'b0);
    #1;
    chk("err_count saturates", 32'(bus.err_count), 32'hFF);

    // Randomized frames with gaps, timeouts, ticks and rare resets.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) < 7) w = secs_to_bcd(int'($urandom_range(0, 86399)));
      else w = 24'($urandom);
      for (int i = 23; i >= 0; i--) begin
        step(w[i], 1'b1, $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) step(1'($urandom), 1'b0, $urandom_range(0, 9) == 0, 1'b0);
        end
        if ($urandom_range(0, 149) == 0) repeat ($urandom_range(TO - 1, TO + 2))
          step(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge wclk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
